// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave with a receive shifter and a transmit shifter.
//
// The SPI pins are brought into the clk domain through SYNC_STAGES flops.
// All edges are detected on the synchronized copies only.
// Received words come out MSB first on rx_data, with a one-cycle rx_valid strobe.
// Transmit words are handed in through a one-word holding buffer (tx_data/tx_valid/tx_ready).
// The transmit shifter drives spi_miso.
//
// Ports
//   clk, rst      system clock (rising edge) and asynchronous active-high reset
//   spi_sclk      SPI clock, CPOL=0 / CPHA=0
//   spi_cs_n      chip select, active low
//   spi_mosi      master-out data
//   spi_miso      slave-out data (MSB of the TX shifter while a frame is active)
//   spi_miso_oe   MISO output enable, high during a frame
//   rx_data       last completed received word
//   rx_valid      one-cycle pulse when rx_data updates
//   tx_data       next word to transmit
//   tx_valid      tx_data is valid
//   tx_ready      the TX holding buffer is empty
//   frame_active  a CS-low frame is in progress
//   rx_abort      one-cycle pulse when CS rises with a partial word
//   tx_underrun   one-cycle pulse when the TX shifter reloads from an empty buffer
//   word_count    completed words in the current frame, saturating at 255
module spi_slave_rx #(
    parameter int WORD_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              frame_active,
    output logic              rx_abort,
    output logic              tx_underrun,
    output logic [7:0]        word_count
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_prev, cs_prev;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic             start, stop;
    logic             shift_bit, fall_evt, last_bit;
    logic             reload, tx_accept;
    logic [CNT_W-1:0] bit_cnt;
    logic             word_done;
    logic [WORD_W-1:0] rx_shift;
    logic [WORD_W-1:0] tx_shift;
    logic [WORD_W-1:0] tx_buf;
    logic             buf_full;
    logic             reload_pending;

    // Synchronizer chains.
    // Reset loads the idle bus levels so that leaving reset cannot look like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sclk_sync[0] <= spi_sclk;
            cs_sync[0]   <= spi_cs_n;
            mosi_sync[0] <= spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                cs_sync[i]   <= cs_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Previous synchronized levels, used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign cs_rise   = cs_s & ~cs_prev;

    // Next-state logic.
    // start and stop mark the single cycle in which a frame opens or closes.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        stop       = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    next_state = SHIFT;
                    start      = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    next_state = IDLE;
                    stop       = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A CS rise takes priority over SCLK edges seen in the same cycle.
    assign shift_bit = (state == SHIFT) && !cs_rise && sclk_rise;
    assign fall_evt  = (state == SHIFT) && !cs_rise && sclk_fall;
    assign last_bit  = (bit_cnt == CNT_W'(WORD_W - 1));
    assign reload    = start || (fall_evt && reload_pending);
    assign tx_accept = tx_valid && !buf_full;

    // State register and the frame-level status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            frame_active <= 1'b0;
            spi_miso_oe  <= 1'b0;
            rx_abort     <= 1'b0;
        end else begin
            state    <= next_state;
            rx_abort <= stop && (bit_cnt != '0);
            if (start) begin
                frame_active <= 1'b1;
                spi_miso_oe  <= 1'b1;
            end else if (stop) begin
                frame_active <= 1'b0;
                spi_miso_oe  <= 1'b0;
            end
        end
    end

    // Receive path.
    // word_done delays the word hand-off by one cycle after the wrapping SCLK rise.
    // Any partial word is dropped: the next frame restarts at bit 0 and shifts in a full word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            word_done  <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            word_count <= '0;
        end else begin
            word_done <= shift_bit && last_bit;
            rx_valid  <= word_done;
            if (start || stop) begin
                bit_cnt <= '0;
            end else if (shift_bit) begin
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end
            if (shift_bit) begin
                rx_shift <= {rx_shift[WORD_W-2:0], mosi_s};
            end
            if (word_done) begin
                rx_data <= rx_shift;
            end
            if (start) begin
                word_count <= '0;
            end else if (word_done && (word_count != 8'hFF)) begin
                word_count <= word_count + 8'd1;
            end
        end
    end

    // Transmit path.
    // The shifter loads at frame start and on the first SCLK fall after each word wrap.
    // On any other SCLK fall it shifts left.
    // A reload takes the buffered word, or zero with tx_underrun if the buffer is empty.
    // tx_ready depends only on buf_full, so a buffered word reloaded in a cycle keeps
    // tx_ready low for that cycle.
    // The buffer is not touched by CS rise, so a held word carries over into the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift       <= '0;
            tx_buf         <= '0;
            buf_full       <= 1'b0;
            reload_pending <= 1'b0;
            tx_underrun    <= 1'b0;
        end else begin
            tx_underrun <= reload && !buf_full;
            if (reload) begin
                tx_shift <= buf_full ? tx_buf : '0;
            end else if (fall_evt) begin
                tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
            end
            if (tx_accept) begin
                tx_buf   <= tx_data;
                buf_full <= 1'b1;
            end else if (reload) begin
                buf_full <= 1'b0;
            end
            if (start || stop) begin
                reload_pending <= 1'b0;
            end else if (shift_bit && last_bit) begin
                reload_pending <= 1'b1;
            end else if (reload) begin
                reload_pending <= 1'b0;
            end
        end
    end

    assign tx_ready = ~buf_full;
    assign spi_miso = frame_active & tx_shift[WORD_W-1];

endmodule
